// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO pointer interface: producer request/clear in, address, pointer and status out.
// Latency: none; signal bundle only.
// Backpressure: the producer watches wfull; a write requested while full is dropped and flagged.
// Ports: master = producer / test side, slave = wptr_full_ctrl.
interface wptr_full_ctrl_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;          // write request
    logic [ADDRSIZE:0]   rptr_gray;     // Gray read pointer from the read domain (async)
    logic                wovf_clr;      // clear sticky overflow
    logic [ADDRSIZE-1:0] waddr;         // binary memory write address
    logic [ADDRSIZE:0]   wptr;          // Gray write pointer to the read domain
    logic                wfull;         // full flag
    logic                walmost_full;  // almost-full flag
    logic [ADDRSIZE:0]   wlevel;        // write-side occupancy 0..DEPTH
    logic                woverflow;     // sticky overflow flag

    modport master (
        output winc, rptr_gray, wovf_clr,
        input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, rptr_gray, wovf_clr,
        output waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/almost-full/level/overflow control for an async FIFO.
// Latency: accepted write moves waddr/wptr/wlevel on the same edge; read-pointer moves are seen 3 edges later.
// Backpressure: wfull blocks writes; a write attempted while full is dropped and sets sticky woverflow.
// Ports: wclk (only clock), wrst_n (async active-low reset), wif (slave modport: winc, rptr_gray,
//        wovf_clr in; waddr, wptr, wfull, walmost_full, wlevel, woverflow out).
module wptr_full_ctrl #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
    input  logic            wclk,
    input  logic            wrst_n,
    wptr_full_ctrl_if.slave wif
);
    localparam int PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wq1_rptr_q, wq1_rptr_d;
    logic [ADDRSIZE:0] wq2_rptr_q, wq2_rptr_d;
    logic              wfull_q, wfull_d;
    logic              walmost_full_q, walmost_full_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic              woverflow_q, woverflow_d;

    logic              wen;
    logic [ADDRSIZE:0] wq2_rbin;

    always_comb begin
        wen      = wif.winc && !wfull_q;
        wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, wen};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;

        // Plain two-flop synchronizer: nothing between the stages.
        wq1_rptr_d = wif.rptr_gray;
        wq2_rptr_d = wq1_rptr_q;

        // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
        wq2_rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wq2_rbin[i] = ^(wq2_rptr_q >> i);
        end

        // Occupancy from the next write pointer so a simultaneous write and
        // synchronized read advance both show up on the same edge.
        wlevel_d       = wbin_d - wq2_rbin;
        walmost_full_d = (wlevel_d >= AFULL_LVL);

        // Full when the next Gray pointer equals the synced read pointer with
        // its top two bits inverted (one lap ahead in Gray space).
        wfull_d = (wptr_d == {~wq2_rptr_q[ADDRSIZE:ADDRSIZE-1], wq2_rptr_q[ADDRSIZE-2:0]});

        // Set has priority over clear.
        if (wif.winc && wfull_q) begin
            woverflow_d = 1'b1;
        end else if (wif.wovf_clr) begin
            woverflow_d = 1'b0;
        end else begin
            woverflow_d = woverflow_q;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wq1_rptr_q     <= '0;
            wq2_rptr_q     <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wq1_rptr_q     <= wq1_rptr_d;
            wq2_rptr_q     <= wq2_rptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign wif.waddr        = wbin_q[ADDRSIZE-1:0];
    assign wif.wptr         = wptr_q;
    assign wif.wfull        = wfull_q;
    assign wif.walmost_full = walmost_full_q;
    assign wif.wlevel       = wlevel_q;
    assign wif.woverflow    = woverflow_q;
endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 Parameter ADDRSIZE, default 4, memory address width; DEPTH = 2**ADDRSIZE.
REQ-002 Parameter AFULL_THRESH, default DEPTH-2, occupancy at or above which walmost_full asserts; legal range 1..DEPTH.
REQ-003 Port wclk  input  1  write-domain clock; the only clock; all flops rising-edge.
REQ-004 Port wrst_n  input  1  asynchronous active-low reset.
REQ-005 Port winc  input  1  write request from producer.
REQ-006 Port rptr_gray  input  ADDRSIZE+1  Gray-coded read pointer from the read domain; asynchronous to wclk.
REQ-007 Port wovf_clr  input  1  synchronous clear of the sticky overflow flag.
REQ-008 Port waddr  output  ADDRSIZE  binary write address to the dual-port memory.
REQ-009 Port wptr  output  ADDRSIZE+1  registered Gray write pointer to the read domain.
REQ-010 Port wfull  output  1  registered full flag; also drives the memory wfull input.
REQ-011 Port walmost_full  output  1  registered almost-full flag.
REQ-012 Port wlevel  output  ADDRSIZE+1  registered write-side occupancy, 0..DEPTH.
REQ-013 Port woverflow  output  1  sticky flag: write attempted while full.

Function
REQ-014 Write accept: wen = winc && !wfull; only wen advances pointers.
REQ-015 Binary counter wbin (ADDRSIZE+1 bits): wbinnext = wbin + wen, modulo 2**(ADDRSIZE+1); wrap from all-ones to 0 is legal.
REQ-016 wgraynext = (wbinnext >> 1) ^ wbinnext; wbin and wptr both register on the same edge.
REQ-017 waddr = wbin[ADDRSIZE-1:0], so address wraps DEPTH-1 -> 0.
REQ-018 rptr_gray passes through a two-flop synchronizer (wq1_rptr, wq2_rptr); no logic between the stages.
REQ-019 wfull registers (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
REQ-020 wfull asserts on the same edge that accepts the DEPTH-th outstanding write.
REQ-021 A read-side pointer change reaches wq2_rptr on the 2nd wclk edge; wfull deasserts on the 3rd.
REQ-022 wq2_rbin = Gray-to-binary of wq2_rptr; wlevel registers (wbinnext - wq2_rbin) modulo 2**(ADDRSIZE+1).
REQ-023 walmost_full registers (wbinnext - wq2_rbin) >= AFULL_THRESH, updating on the same edge as wlevel.
REQ-024 Overflow: winc && wfull sets woverflow on the next edge; wovf_clr clears it; set wins when both occur in one cycle.
REQ-025 Rejected write (winc && wfull): wbin, wptr, waddr, wlevel unchanged.
REQ-026 Simultaneous write accept and read-pointer advance: wlevel reflects both in the cycle the synchronized pointer lands; no lost update.

Reset
REQ-027 wrst_n low immediately forces, with no clock edge: wbin=0, wptr=0, waddr=0, wq1_rptr=0, wq2_rptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
REQ-028 Reset release is synchronous to wclk; first write is accepted on the first rising edge with wrst_n high and winc=1.
REQ-029 Reset mid-operation discards pointer state; no partial-write recovery.

Verification (ADDRSIZE=4, AFULL_THRESH=14)
REQ-030 Reset: assert wrst_n=0 mid-cycle -> all outputs 0 before the next wclk edge.
REQ-031 Fill: rptr_gray=0, winc=1 for 16 edges -> wfull=1 at 16th edge, wlevel=16, wptr=5'b11000, waddr=0; walmost_full=1 from 14th edge.
REQ-032 Overflow: while full, winc=1 for 1 cycle -> wptr holds 5'b11000, woverflow=1 next edge; wovf_clr=1 -> woverflow=0 next edge; winc=1 and wovf_clr=1 together -> woverflow=1.
REQ-033 Release: from full, rptr_gray=5'b00001 -> wfull=0 and wlevel=15 on 3rd wclk edge; walmost_full stays 1.
REQ-034 Wrap: write 40 entries while rptr_gray tracks wptr delayed by 4 writes -> wfull never asserts, waddr wraps 15->0, wbin wraps 31->0 with wlevel continuous.
REQ-035 Mid-operation reset: after 5 writes (waddr=5), pulse wrst_n low -> waddr=0, wlevel=0; next accepted write uses waddr=0.
